// File: rtl/fir_cap_pkg.sv
// Shared types and default sizing for the FIR capture buffer controller.
package fir_cap_pkg;

    localparam int DEF_DATA_W = 23;
    localparam int DEF_DEPTH  = 1300;
    localparam int DEF_ADDR_W = 11;

    // Avalon-ST error code for a good sample
    localparam logic [1:0] ERR_OK = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE,
        ST_READOUT
    } state_t;

endpackage

// File: rtl/fir_capture_ctrl_if.sv
// Sample stream (Avalon-ST sink side) and readout bus of the capture buffer.
interface fir_capture_ctrl_if import fir_cap_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [DATA_W-1:0] ast_sink_data;
    logic              ast_sink_valid;
    logic [1:0]        ast_sink_error;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;

    // master: FIR source plus readout client; slave: the capture controller
    modport master (
        output ast_sink_data,
        output ast_sink_valid,
        output ast_sink_error,
        output rd_req,
        input  rd_data,
        input  rd_valid,
        input  rd_last
    );

    modport slave (
        input  ast_sink_data,
        input  ast_sink_valid,
        input  ast_sink_error,
        input  rd_req,
        output rd_data,
        output rd_valid,
        output rd_last
    );

endinterface

// File: rtl/cap_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module cap_ram #(
    parameter int DATA_W = 23,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // No reset on storage or read register so this maps onto block RAM
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fir_capture_ctrl.sv
// Captures DEPTH good FIR samples into a buffer, then plays them back on request.
module fir_capture_ctrl import fir_cap_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    fir_capture_ctrl_if.slave   bus,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     count,
    output logic                err_flag
);

    localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            state_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic              err_flag_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              rd_valid_reg;
    logic              rd_last_reg;
    logic [DATA_W-1:0] ram_q;
    logic              sample_ok;
    logic              sample_bad;
    logic              wr_en;
    logic              rd_en;

    assign sample_ok  = bus.ast_sink_valid && (bus.ast_sink_error == ERR_OK);
    assign sample_bad = bus.ast_sink_valid && (bus.ast_sink_error != ERR_OK);

    // abort wins over any same-cycle write or read
    assign wr_en = !abort && (state_reg == ST_CAPTURE) && sample_ok;
    assign rd_en = !abort && ((state_reg == ST_DONE) || (state_reg == ST_READOUT)) && bus.rd_req;

    cap_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_cap_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (count_reg[ADDR_W-1:0]),
        .wr_data (bus.ast_sink_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_reg),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            err_flag_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_last_reg  <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en;
            rd_last_reg  <= rd_en && (rd_ptr_reg == LAST_PTR);
            if (abort) begin
                // counters and error flag are left for inspection until the next start
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            state_reg    <= ST_CAPTURE;
                            busy_reg     <= 1'b1;
                            count_reg    <= '0;
                            rd_ptr_reg   <= '0;
                            err_flag_reg <= 1'b0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (sample_bad) begin
                            err_flag_reg <= 1'b1;
                        end
                        if (wr_en) begin
                            count_reg <= count_reg + 1'b1;
                            if (count_reg == LAST_CNT) begin
                                state_reg <= ST_DONE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end
                        end
                    end
                    ST_DONE, ST_READOUT: begin
                        if (rd_en) begin
                            if (rd_ptr_reg == LAST_PTR) begin
                                state_reg <= ST_IDLE;
                                done_reg  <= 1'b0;
                            end else begin
                                state_reg  <= ST_READOUT;
                                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // read data is forced to zero whenever it is not qualified, so reset clears it at once
    assign bus.rd_data  = rd_valid_reg ? ram_q : '0;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.rd_last  = rd_last_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign count        = count_reg;
    assign err_flag     = err_flag_reg;

endmodule
